// File: rtl/uart8.sv
// uart8: full-duplex 8N1 UART with an independent transmitter and an oversampling receiver.
// Optional build macro UART8_RX_MAJORITY_EN: every RX sample becomes a 2-of-3 vote around the bit centre.
module uart8 #(
    parameter int CLOCK_RATE         = 12000000,
    parameter int BAUD_RATE          = 9600,
    parameter int RX_OVERSAMPLE_RATE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxEn,
    input  logic       rxIn,
    output logic       rxBusy,
    output logic       rxDone,
    output logic       rxErr,
    output logic [7:0] rxOut,
    input  logic       txEn,
    input  logic       txStart,
    input  logic [7:0] txIn,
    output logic       txBusy,
    output logic       txDone,
    output logic       txOut
);
    localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
    localparam int RX_DIV = CLOCK_RATE / (BAUD_RATE * RX_OVERSAMPLE_RATE);
    localparam int TX_CW  = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
    localparam int RX_DW  = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
    localparam int OS_W   = $clog2(RX_OVERSAMPLE_RATE);
`ifdef UART8_RX_MAJORITY_EN
    localparam int SAMPLE_LAG = 1;
`else
    localparam int SAMPLE_LAG = 0;
`endif
    localparam logic [TX_CW-1:0] TX_LAST    = TX_CW'(TX_DIV - 1);
    localparam logic [RX_DW-1:0] RX_LAST    = RX_DW'(RX_DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST    = OS_W'(RX_OVERSAMPLE_RATE - 1);
    localparam logic [OS_W-1:0]  START_LAST = OS_W'(RX_OVERSAMPLE_RATE / 2 - 1 + SAMPLE_LAG);

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} txState_t;

    txState_t         txStateReg, txStateNext;
    logic [TX_CW-1:0] txCntReg, txCntNext;
    logic [2:0]       txBitReg, txBitNext;
    logic [7:0]       txShiftReg, txShiftNext;
    logic             txOutReg, txOutNext;
    logic             txBusyReg, txBusyNext;
    logic             txDoneReg, txDoneNext;

    always_ff @(posedge clk) begin
        if (reset) begin
            txStateReg <= TX_IDLE;
            txCntReg   <= '0;
            txBitReg   <= '0;
            txShiftReg <= '0;
            txOutReg   <= 1'b1;
            txBusyReg  <= 1'b0;
            txDoneReg  <= 1'b0;
        end else begin
            txStateReg <= txStateNext;
            txCntReg   <= txCntNext;
            txBitReg   <= txBitNext;
            txShiftReg <= txShiftNext;
            txOutReg   <= txOutNext;
            txBusyReg  <= txBusyNext;
            txDoneReg  <= txDoneNext;
        end
    end

    // The line level is registered from the current state, so each bit
    // appears on txOut one clock after the state that owns it is entered.
    always_comb begin
        txStateNext = txStateReg;
        txCntNext   = txCntReg;
        txBitNext   = txBitReg;
        txShiftNext = txShiftReg;
        txOutNext   = 1'b1;
        txBusyNext  = txBusyReg;
        txDoneNext  = txDoneReg;
        if (!txEn) begin
            txStateNext = TX_IDLE;
            txCntNext   = '0;
            txBitNext   = '0;
            txBusyNext  = 1'b0;
            txDoneNext  = 1'b0;
        end else begin
            case (txStateReg)
                TX_IDLE, TX_DONE: begin
                    if (txStart) begin
                        txStateNext = TX_START;
                        txShiftNext = txIn;
                        txCntNext   = '0;
                        txBitNext   = '0;
                        txBusyNext  = 1'b1;
                        txDoneNext  = 1'b0;
                    end
                end
                TX_START: begin
                    txOutNext = 1'b0;
                    if (txCntReg == TX_LAST) begin
                        txCntNext   = '0;
                        txStateNext = TX_DATA;
                    end else begin
                        txCntNext = txCntReg + 1'b1;
                    end
                end
                TX_DATA: begin
                    txOutNext = txShiftReg[0];
                    if (txCntReg == TX_LAST) begin
                        txCntNext   = '0;
                        txShiftNext = {1'b0, txShiftReg[7:1]};
                        txBitNext   = txBitReg + 3'd1;
                        if (txBitReg == 3'd7) begin
                            txStateNext = TX_STOP;
                        end
                    end else begin
                        txCntNext = txCntReg + 1'b1;
                    end
                end
                TX_STOP: begin
                    txOutNext = 1'b1;
                    if (txCntReg == TX_LAST) begin
                        txCntNext   = '0;
                        txStateNext = TX_DONE;
                        txBusyNext  = 1'b0;
                        txDoneNext  = 1'b1;
                    end else begin
                        txCntNext = txCntReg + 1'b1;
                    end
                end
                default: txStateNext = TX_IDLE;
            endcase
        end
    end

    assign txOut  = txOutReg;
    assign txBusy = txBusyReg;
    assign txDone = txDoneReg;

    // ---------------- receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

    logic             rxSync1Reg, rxSync2Reg;
    logic [RX_DW-1:0] rxDivReg;
    logic             rxTick;
    logic             rxSample;
    rxState_t         rxStateReg, rxStateNext;
    logic [OS_W-1:0]  rxTickCntReg, rxTickCntNext;
    logic [2:0]       rxBitReg, rxBitNext;
    logic [7:0]       rxShiftReg, rxShiftNext;
    logic [7:0]       rxOutReg, rxOutNext;
    logic             rxBusyReg, rxBusyNext;
    logic             rxDoneReg, rxDoneNext;
    logic             rxErrReg, rxErrNext;

    assign rxTick = (rxDivReg == RX_LAST);

`ifdef UART8_RX_MAJORITY_EN
    // Line values at the two previous ticks; the vote lands one tick after the centre.
    logic [1:0] rxHistReg;
    always_ff @(posedge clk) begin
        if (reset) begin
            rxHistReg <= 2'b11;
        end else if (rxTick) begin
            rxHistReg <= {rxHistReg[0], rxSync2Reg};
        end
    end
    assign rxSample = (rxSync2Reg & rxHistReg[0]) | (rxSync2Reg & rxHistReg[1]) |
                      (rxHistReg[0] & rxHistReg[1]);
`else
    assign rxSample = rxSync2Reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rxSync1Reg   <= 1'b1;
            rxSync2Reg   <= 1'b1;
            rxDivReg     <= '0;
            rxStateReg   <= RX_IDLE;
            rxTickCntReg <= '0;
            rxBitReg     <= '0;
            rxShiftReg   <= '0;
            rxOutReg     <= '0;
            rxBusyReg    <= 1'b0;
            rxDoneReg    <= 1'b0;
            rxErrReg     <= 1'b0;
        end else begin
            rxSync1Reg   <= rxIn;
            rxSync2Reg   <= rxSync1Reg;
            rxDivReg     <= rxTick ? '0 : rxDivReg + 1'b1;
            rxStateReg   <= rxStateNext;
            rxTickCntReg <= rxTickCntNext;
            rxBitReg     <= rxBitNext;
            rxShiftReg   <= rxShiftNext;
            rxOutReg     <= rxOutNext;
            rxBusyReg    <= rxBusyNext;
            rxDoneReg    <= rxDoneNext;
            rxErrReg     <= rxErrNext;
        end
    end

    always_comb begin
        rxStateNext   = rxStateReg;
        rxTickCntNext = rxTickCntReg;
        rxBitNext     = rxBitReg;
        rxShiftNext   = rxShiftReg;
        rxOutNext     = rxOutReg;
        rxBusyNext    = rxBusyReg;
        rxDoneNext    = rxDoneReg;
        rxErrNext     = rxErrReg;
        if (!rxEn) begin
            rxStateNext   = RX_IDLE;
            rxTickCntNext = '0;
            rxBitNext     = '0;
            rxBusyNext    = 1'b0;
            rxDoneNext    = 1'b0;
            rxErrNext     = 1'b0;
        end else if (rxTick) begin
            case (rxStateReg)
                RX_IDLE: begin
                    if (!rxSync2Reg) begin
                        rxStateNext   = RX_START;
                        rxTickCntNext = '0;
                        rxBusyNext    = 1'b1;
                        rxDoneNext    = 1'b0;
                        rxErrNext     = 1'b0;
                    end
                end
                RX_START: begin
                    if (rxTickCntReg == START_LAST) begin
                        rxTickCntNext = '0;
                        rxBitNext     = '0;
                        if (rxSample) begin
                            rxStateNext = RX_IDLE;
                            rxBusyNext  = 1'b0;
                        end else begin
                            rxStateNext = RX_DATA;
                        end
                    end else begin
                        rxTickCntNext = rxTickCntReg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rxTickCntReg == OS_LAST) begin
                        rxTickCntNext = '0;
                        rxShiftNext   = {rxSample, rxShiftReg[7:1]};
                        rxBitNext     = rxBitReg + 3'd1;
                        if (rxBitReg == 3'd7) begin
                            rxStateNext = RX_STOP;
                        end
                    end else begin
                        rxTickCntNext = rxTickCntReg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rxTickCntReg == OS_LAST) begin
                        rxTickCntNext = '0;
                        rxStateNext   = RX_IDLE;
                        rxBusyNext    = 1'b0;
                        if (rxSample) begin
                            rxOutNext  = rxShiftReg;
                            rxDoneNext = 1'b1;
                        end else begin
                            rxErrNext = 1'b1;
                        end
                    end else begin
                        rxTickCntNext = rxTickCntReg + 1'b1;
                    end
                end
                default: rxStateNext = RX_IDLE;
            endcase
        end
    end

    assign rxBusy = rxBusyReg;
    assign rxDone = rxDoneReg;
    assign rxErr  = rxErrReg;
    assign rxOut  = rxOutReg;

endmodule

// File: tb/tb_uart8.sv
// Scoreboard bench for uart8: instance A transmits into instance B's receiver (or the bench drives B.rxIn);
// a monitor pops expected bytes whenever B raises rxDone/rxErr.
`timescale 1ns/1ps
module tb_uart8;
    localparam int CLOCK_RATE = 12000000;
    localparam int BAUD_RATE  = 176470;
    localparam int OS_RATE    = 17;
    localparam int TX_DIV     = CLOCK_RATE / BAUD_RATE;   // 68 clocks per bit, RX_DIV 4

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       aRxEn, aRxBusy, aRxDone, aRxErr;
    logic [7:0] aRxOut;
    logic       aTxEn, aTxStart, aTxBusy, aTxDone, aTxOut;
    logic [7:0] aTxIn;
    logic       bRxEn, bRxBusy, bRxDone, bRxErr, bRxIn;
    logic [7:0] bRxOut;
    logic       bTxEn, bTxStart, bTxBusy, bTxDone, bTxOut;
    logic [7:0] bTxIn;
    logic       loopSel, drvRx;

    exp_t       expQ[$];
    int         passCnt  = 0;
    int         totalCnt = 0;
    logic [7:0] lastGood = 8'h00;

    assign bRxIn = loopSel ? aTxOut : drvRx;

    always #5 clk = ~clk;

    uart8 #(.CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE), .RX_OVERSAMPLE_RATE(OS_RATE)) uA (
        .clk(clk), .reset(reset),
        .rxEn(aRxEn), .rxIn(bTxOut), .rxBusy(aRxBusy), .rxDone(aRxDone), .rxErr(aRxErr), .rxOut(aRxOut),
        .txEn(aTxEn), .txStart(aTxStart), .txIn(aTxIn), .txBusy(aTxBusy), .txDone(aTxDone), .txOut(aTxOut)
    );

    uart8 #(.CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE), .RX_OVERSAMPLE_RATE(OS_RATE)) uB (
        .clk(clk), .reset(reset),
        .rxEn(bRxEn), .rxIn(bRxIn), .rxBusy(bRxBusy), .rxDone(bRxDone), .rxErr(bRxErr), .rxOut(bRxOut),
        .txEn(bTxEn), .txStart(bTxStart), .txIn(bTxIn), .txBusy(bTxBusy), .txDone(bTxDone), .txOut(bTxOut)
    );

    task automatic checkBit(input string name, input logic act, input logic exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic checkByte(input string name, input logic [7:0] act, input logic [7:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    endtask

    task automatic pushExp(input logic [7:0] d, input logic err);
        exp_t e;
        e.data = d;
        e.err  = err;
        expQ.push_back(e);
    endtask

    task automatic runMonitor();
        logic prevFlag = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if ((bRxDone | bRxErr) && !prevFlag) begin
                $display("rx: byte %02h done %0b err %0b at %0t", bRxOut, bRxDone, bRxErr, $time);
                if (expQ.size() == 0) begin
                    checkBit("rxUnexpected", bRxDone | bRxErr, 1'b0);
                end else begin
                    e = expQ.pop_front();
                    checkByte("rxOut", bRxOut, e.data);
                    checkBit("rxDone", bRxDone, !e.err);
                    checkBit("rxErr", bRxErr, e.err);
                end
            end
            prevFlag = bRxDone | bRxErr;
        end
    endtask

    task automatic waitTxIdle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (aTxBusy && n < 40 * TX_DIV);
    endtask

    task automatic sendFrame(input logic [7:0] d, input int holdClocks);
        @(negedge clk);
        loopSel  = 1'b1;
        aTxIn    = d;
        aTxStart = 1'b1;
        pushExp(d, 1'b0);
        lastGood = d;
        repeat (holdClocks) @(negedge clk);
        aTxStart = 1'b0;
        waitTxIdle();
        $display("tx: byte %02h sent, txBusy %0b txDone %0b at %0t", d, aTxBusy, aTxDone, $time);
        checkBit("txBusyEnd", aTxBusy, 1'b0);
        checkBit("txDoneEnd", aTxDone, 1'b1);
        repeat (2 * TX_DIV) @(negedge clk);
    endtask

    // glitchBit >= 0 puts a one-tick low pulse at the centre of that frame bit.
    task automatic driveRxFrame(input logic [7:0] d, input logic stopBit, input int glitchBit);
        logic [9:0] bits;
        bits = {stopBit, d, 1'b0};
        @(negedge clk);
        loopSel = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drvRx = bits[i];
            if (i == glitchBit) begin
                repeat (TX_DIV / 2 - 2) @(negedge clk);
                drvRx = 1'b0;
                repeat (4) @(negedge clk);
                drvRx = bits[i];
                repeat (TX_DIV / 2 - 2) @(negedge clk);
            end else begin
                repeat (TX_DIV) @(negedge clk);
            end
        end
        drvRx = 1'b1;
        $display("drv: byte %02h stop %0b glitchBit %0d at %0t", d, stopBit, glitchBit, $time);
        repeat (2 * TX_DIV) @(negedge clk);
    endtask

    initial begin
        logic [9:0] wave;
        reset = 1'b1;
        aRxEn = 1'b0; aTxEn = 1'b1; aTxStart = 1'b0; aTxIn = 8'h00;
        bRxEn = 1'b1; bTxEn = 1'b0; bTxStart = 1'b0; bTxIn = 8'h00;
        loopSel = 1'b1; drvRx = 1'b1;
        fork runMonitor(); join_none

        // Reset state
        repeat (5) @(negedge clk);
        checkBit("rstTxOut", aTxOut, 1'b1);
        checkBit("rstTxBusy", aTxBusy, 1'b0);
        checkBit("rstTxDone", aTxDone, 1'b0);
        checkBit("rstRxBusy", bRxBusy, 1'b0);
        checkBit("rstRxDone", bRxDone, 1'b0);
        checkBit("rstRxErr", bRxErr, 1'b0);
        checkByte("rstRxOut", bRxOut, 8'h00);
        reset = 1'b0;
        aRxEn = 1'b1;
        repeat (TX_DIV) @(negedge clk);

        // Loopback, txStart held for three bit times
        sendFrame(8'h8A, 3 * TX_DIV);

        // Loopback with a one-bit-time txStart; txOut sampled mid-bit
        wave = {1'b1, 8'h7A, 1'b0};
        @(negedge clk);
        aTxIn    = 8'h7A;
        aTxStart = 1'b1;
        pushExp(8'h7A, 1'b0);
        lastGood = 8'h7A;
        @(posedge clk);
        fork
            begin
                repeat (TX_DIV) @(negedge clk);
                aTxStart = 1'b0;
            end
            begin
                repeat (1 + TX_DIV / 2) @(posedge clk);
                for (int k = 0; k < 10; k++) begin
                    #1;
                    checkBit($sformatf("txWave%0d", k), aTxOut, wave[k]);
                    repeat (TX_DIV) @(posedge clk);
                end
            end
        join
        waitTxIdle();
        checkBit("txDone7A", aTxDone, 1'b1);
        repeat (2 * TX_DIV) @(negedge clk);

        // txStart left high across a frame boundary: two frames back to back
        pushExp(8'h3C, 1'b0);
        sendFrame(8'h3C, 15 * TX_DIV);

        // Bench-driven frames: good one, then one with a low stop bit
        pushExp(8'hA5, 1'b0);
        lastGood = 8'hA5;
        driveRxFrame(8'hA5, 1'b1, -1);
        pushExp(lastGood, 1'b1);
        driveRxFrame(8'h55, 1'b0, -1);

        // Short low glitch: false start
        @(negedge clk);
        drvRx = 1'b0;
        repeat (10) @(negedge clk);
        drvRx = 1'b1;
        checkBit("glitchBusySeen", bRxBusy, 1'b1);
        repeat (2 * TX_DIV) @(negedge clk);
        checkBit("glitchBusy", bRxBusy, 1'b0);
        checkBit("glitchDone", bRxDone, 1'b0);
        checkBit("glitchErr", bRxErr, 1'b0);
        checkByte("glitchRxOut", bRxOut, lastGood);

`ifdef UART8_RX_MAJORITY_EN
        pushExp(8'hFF, 1'b0);
        lastGood = 8'hFF;
        driveRxFrame(8'hFF, 1'b1, 4);
`endif

        // Drop rxEn, then txEn, in the middle of a loopback frame
        @(negedge clk);
        loopSel  = 1'b1;
        aTxIn    = 8'h96;
        aTxStart = 1'b1;
        repeat (TX_DIV) @(negedge clk);
        aTxStart = 1'b0;
        repeat (3 * TX_DIV) @(negedge clk);
        checkBit("abortRxBusyBefore", bRxBusy, 1'b1);
        checkBit("abortTxBusyBefore", aTxBusy, 1'b1);
        bRxEn = 1'b0;
        @(negedge clk);
        checkBit("abortRxBusy", bRxBusy, 1'b0);
        checkBit("abortRxDone", bRxDone, 1'b0);
        checkBit("abortRxErr", bRxErr, 1'b0);
        checkByte("abortRxOut", bRxOut, lastGood);
        aTxEn = 1'b0;
        @(negedge clk);
        checkBit("abortTxOut", aTxOut, 1'b1);
        checkBit("abortTxBusy", aTxBusy, 1'b0);
        checkBit("abortTxDone", aTxDone, 1'b0);
        aTxEn = 1'b1;
        repeat (2 * TX_DIV) @(negedge clk);
        bRxEn = 1'b1;
        repeat (TX_DIV) @(negedge clk);

        // Reset in the middle of a frame, then a clean frame
        aTxIn    = 8'h5A;
        aTxStart = 1'b1;
        repeat (TX_DIV) @(negedge clk);
        aTxStart = 1'b0;
        repeat (3 * TX_DIV) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkBit("midRstTxOut", aTxOut, 1'b1);
        checkBit("midRstTxBusy", aTxBusy, 1'b0);
        checkBit("midRstTxDone", aTxDone, 1'b0);
        checkBit("midRstRxBusy", bRxBusy, 1'b0);
        checkBit("midRstRxDone", bRxDone, 1'b0);
        checkBit("midRstRxErr", bRxErr, 1'b0);
        checkByte("midRstRxOut", bRxOut, 8'h00);
        checkBit("midRstARxBusy", aRxBusy | aRxDone | aRxErr, 1'b0);
        checkByte("midRstARxOut", aRxOut, 8'h00);
        checkBit("midRstBTx", bTxBusy | bTxDone, 1'b0);
        reset = 1'b0;
        repeat (TX_DIV) @(negedge clk);
        sendFrame(8'hC3, TX_DIV);

        repeat (TX_DIV) @(negedge clk);
        checkByte("scoreboardLeft", 8'(expQ.size()), 8'd0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/uart8.md
# uart8

Full-duplex 8N1 UART with independent transmitter and receiver and a shared clock. The transmitter serialises one byte per `txStart` request. The receiver oversamples the line and delivers a byte with done/error status. It sits between a byte-oriented host interface and the physical serial pins.

## Interface
- `CLOCK_RATE`, default 12000000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: serial bit rate.
- `RX_OVERSAMPLE_RATE`, default 16: receiver ticks per bit; must be ≥ 4.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `rxEn` in 1: receiver enable.
- `rxIn` in 1: serial input, asynchronous; idle high.
- `rxBusy` out 1: receive frame in progress.
- `rxDone` out 1: byte received with a valid stop bit.
- `rxErr` out 1: framing error (stop bit sampled low).
- `rxOut` out 8: last received byte.
- `txEn` in 1: transmitter enable.
- `txStart` in 1: start request; level-sensitive.
- `txIn` in 8: byte to send; latched at start.
- `txBusy` out 1: transmit frame in progress.
- `txDone` out 1: last frame completed.
- `txOut` out 1: serial output; idle high.

## Operation
- Dividers, computed with truncating integer division:
  - TX_DIV = CLOCK_RATE/BAUD_RATE.
  - RX_DIV = CLOCK_RATE/(BAUD_RATE*RX_OVERSAMPLE_RATE).
  - Example: 12 MHz, 9600 baud gives TX_DIV 1250; with oversample 17, RX_DIV is 73.
  - Counter widths are sized with $clog2.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. No parity.
- TX states: IDLE, START, DATA, STOP, DONE.
  - IDLE → START when `txEn` && `txStart`. Latch `txIn`, clear `txDone`, set `txBusy`.
  - DATA shifts 8 bits.
  - STOP → DONE: drop `txBusy`, set `txDone`.
  - DONE behaves as IDLE. `txDone` stays high until the next accepted start or until `txEn` goes low.
  - `txStart` still high in DONE/IDLE starts another frame immediately. Frames are back-to-back.
- `txEn` low: transmitter returns to IDLE at once. `txOut`=1, `txBusy`=0, `txDone`=0; any in-flight frame is aborted.
- `rxIn` passes through a 2-flop synchroniser before use.
- RX states: IDLE, START, DATA, STOP.
  - All RX logic advances on oversample ticks (every RX_DIV clocks).
  - IDLE → START on synchronised `rxIn`==0 with `rxEn` high. Set `rxBusy`, clear `rxDone`/`rxErr`.
  - START: sample at tick RX_OVERSAMPLE_RATE/2. If high, it is a false start: return to IDLE, clear `rxBusy`, no flags.
  - DATA: sample each bit every RX_OVERSAMPLE_RATE ticks after the start-bit centre. Shift LSB first.
  - STOP: sample at stop-bit centre.
    - High: `rxOut` ← shift register, `rxDone`=1.
    - Low: `rxErr`=1, `rxOut` unchanged.
    - Either case: `rxBusy`=0, go to IDLE.
- `rxDone`/`rxErr` hold until the next start-bit detection, `rxEn` low, or reset.
- `rxEn` low: receiver returns to IDLE. `rxBusy`/`rxDone`/`rxErr` are cleared; `rxOut` is retained.
- Reset values: `txOut`=1; `txBusy`, `txDone`, `rxBusy`, `rxDone`, `rxErr`=0; `rxOut`=8'h00. Both FSMs go to IDLE and all counters clear. Reset overrides any in-progress frame.

## Timing
- `txStart` sampled high at edge N: `txOut` is 0 from edge N+1.
  - Each bit lasts exactly TX_DIV clocks; the frame lasts 10·TX_DIV clocks.
  - `txDone`↑ and `txBusy`↓ occur on the same edge, at the end of the stop bit.
- RX latency:
  - Start detection is up to RX_DIV+2 clocks after the falling line edge (synchroniser plus tick alignment).
  - `rxDone` rises within one RX_DIV after the stop-bit centre.
  - `rxOut` is valid on the same edge that `rxDone` rises.
- TX and RX are fully independent; simultaneous operation and loopback are supported.
- Tolerated sender/receiver rate mismatch is at least ±2% for RX_OVERSAMPLE_RATE 16 or 17.

## Configuration
- `UART8_RX_MAJORITY_EN` defined: every RX bit sample is the 2-of-3 majority of the synchronised line at ticks centre−1, centre and centre+1. This applies to the start-confirm sample as well. Decisions and flags land one tick later.
- `UART8_RX_MAJORITY_EN` undefined: a single sample at the centre tick.
- Frame format and the remaining timing are identical in both builds.

## Test plan
- Two instances in loopback: A.txOut→B.rxIn, CLOCK_RATE 12 MHz, RX_OVERSAMPLE_RATE 17. Send 8'b10001010 with `txStart` held for 3 bit times → B.`rxOut`=8'h8A, `rxDone`=1, `rxErr`=0. A.`txDone`=1 and A.`txBusy`=0 after roughly 10·1250 clocks.
- Same setup, then send 8'b01111010 with a 1-bit-time `txStart` → `rxOut`=8'h7A, `rxDone`=1. `txOut` waveform: 0, 0,1,0,1,1,1,1,0, 1.
- Drive `rxIn` with a 0x55 frame whose stop bit is 0 → `rxErr`=1, `rxDone`=0, `rxOut` unchanged.
- Drive `rxIn` with a low glitch shorter than ⅓ bit → `rxBusy` returns to 0 and no flags are set. With `UART8_RX_MAJORITY_EN`, a single-tick glitch at a data-bit centre does not corrupt the byte.
- Drop `rxEn` mid-frame, then drop `txEn` mid-frame → `rxBusy`/`rxDone`/`rxErr`=0, `txOut`=1, `txBusy`=0 on the next edge.
- Assert `reset` mid-frame → all outputs take their reset values on the next edge. After `reset` deasserts, the next full frame is received correctly.
